// File: rtl/gray_stream.sv
// gray_stream: two-stage valid/ready RGB-to-grey converter.
// Modes (sampled per accepted pixel): 0 lightness, 1 average, 2 luma, 3 bypass.
// Optional build macro GRAY_REPLICATE_EN: when defined, modes 0-2 emit {g,g,g};
// otherwise grey appears in the G field only, with R and B zero.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. in_ready is the pipe-advance enable (!out_valid | out_ready) and does not
// depend on in_valid. While the enable is low both stages hold everything.
module gray_stream #(
  parameter int CW    = 8,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3*CW-1:0]   in_pix,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3*CW-1:0]   out_pix,
  output logic [CNT_W-1:0]  px_count
);

  localparam int PW = 3 * CW;
  localparam int SW = CW + 2;
  localparam int YW = CW + 8;

  // Stage-1 registers
  logic          r_s1_valid;
  logic [1:0]    r_s1_mode;
  logic [CW-1:0] r_s1_max;
  logic [CW-1:0] r_s1_min;
  logic [SW-1:0] r_s1_s3;
  logic [YW-1:0] r_s1_y;
  logic [PW-1:0] r_s1_raw;

  // Stage-2 (output) registers
  logic             r_out_valid;
  logic [PW-1:0]    r_out_pix;
  logic [CNT_W-1:0] r_px_count;

  // Combinational signals
  logic          w_en;
  logic [CW-1:0] w_r;
  logic [CW-1:0] w_g;
  logic [CW-1:0] w_b;
  logic [CW-1:0] w_max;
  logic [CW-1:0] w_min;
  logic [SW-1:0] w_s3;
  logic [YW-1:0] w_y;
  logic [CW:0]   w_light_sum;
  logic [SW-1:0] w_avg_full;
  logic [CW-1:0] w_gray;
  logic [PW-1:0] w_out_pix;

  assign w_en      = !r_out_valid || out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_out_valid;
  assign out_pix   = r_out_pix;
  assign px_count  = r_px_count;

  assign w_r = in_pix[3*CW-1:2*CW];
  assign w_g = in_pix[2*CW-1:CW];
  assign w_b = in_pix[CW-1:0];

  // Stage-1 arithmetic: channel extremes, plain sum and weighted luma sum
  always_comb begin
    w_max = w_r;
    w_min = w_r;
    if (w_g > w_max) w_max = w_g;
    if (w_b > w_max) w_max = w_b;
    if (w_g < w_min) w_min = w_g;
    if (w_b < w_min) w_min = w_b;
    w_s3 = SW'(w_r) + SW'(w_g) + SW'(w_b);
    w_y  = YW'(77) * YW'(w_r) + YW'(150) * YW'(w_g) + YW'(29) * YW'(w_b);
  end

  // Stage-1 register: capture features of the accepted pixel when the pipe advances
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_mode  <= 2'd0;
      r_s1_max   <= '0;
      r_s1_min   <= '0;
      r_s1_s3    <= '0;
      r_s1_y     <= '0;
      r_s1_raw   <= '0;
    end else if (w_en) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_mode <= mode;
        r_s1_max  <= w_max;
        r_s1_min  <= w_min;
        r_s1_s3   <= w_s3;
        r_s1_y    <= w_y;
        r_s1_raw  <= in_pix;
      end
    end
  end

  // Stage-2 arithmetic: pick the grey value for the stage-1 mode and pack it
  always_comb begin
    w_light_sum = {1'b0, r_s1_max} + {1'b0, r_s1_min};
    w_avg_full  = r_s1_s3 / SW'(3);
    w_gray      = '0;
    case (r_s1_mode)
      2'd0:    w_gray = w_light_sum[CW:1];
      2'd1:    w_gray = w_avg_full[CW-1:0];
      2'd2:    w_gray = r_s1_y[YW-1:8];
      default: w_gray = '0;
    endcase
`ifdef GRAY_REPLICATE_EN
    w_out_pix = {w_gray, w_gray, w_gray};
`else
    w_out_pix = {{CW{1'b0}}, w_gray, {CW{1'b0}}};
`endif
    if (r_s1_mode == 2'd3) w_out_pix = r_s1_raw;
  end

  // Stage-2 register: output valid always follows stage 1; data only loads on a real pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_pix   <= '0;
    end else if (w_en) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) r_out_pix <= w_out_pix;
    end
  end

  // Output-transfer counter, wraps naturally at its width
  always_ff @(posedge clk) begin
    if (rst) begin
      r_px_count <= '0;
    end else if (r_out_valid && out_ready) begin
      r_px_count <= r_px_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_gray_stream.sv
// Testbench for gray_stream (CW=8, CNT_W=16).
module tb_gray_stream;

  logic        clk;
  logic        rst;
  logic [1:0]  mode;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_pix;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_pix;
  logic [15:0] px_count;

  gray_stream #(.CW(8), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pix    (in_pix),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pix   (out_pix),
    .px_count  (px_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [23:0] exp_q[$];
  int          xfer_cyc[$];
  logic [15:0] exp_cnt = 16'd0;
  logic [23:0] cur_exp = 24'd0;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic logic [23:0] pack(input logic [1:0] m, input logic [7:0] g,
                                       input logic [23:0] raw);
    if (m == 2'd3) return raw;
`ifdef GRAY_REPLICATE_EN
    return {g, g, g};
`else
    return {8'h00, g, 8'h00};
`endif
  endfunction

  // Monitor: output data, transfer count and unexpected outputs, sampled on negedge
  always @(negedge clk) begin
    if (!rst) begin
      check("px_count", {16'd0, px_count}, {16'd0, exp_cnt});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", {31'd0, out_valid}, 32'd0);
        end else begin
          check("out_pix", {8'd0, out_pix}, {8'd0, exp_q.pop_front()});
        end
        exp_cnt = exp_cnt + 16'd1;
        xfer_cyc.push_back(cyc);
      end
      if (in_valid && in_ready) exp_q.push_back(cur_exp);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [1:0] m, input logic [23:0] pix, input logic [23:0] e);
    bit ok;
    @(posedge clk); #1;
    in_valid = 1'b1;
    mode     = m;
    in_pix   = pix;
    cur_exp  = e;
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) begin
        ok = 1;
        break;
      end
    end
    check("drain_done", {31'd0, ok}, 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    exp_cnt  = 16'd0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  m;
    logic [23:0] pix;
    logic [7:0]  g;
  } vec_t;

  vec_t vecs[14];

  logic [23:0] hold_pix;
  bit          have_hold;
  int          stab_bad;
  int          acc;
  bit          rnd_done;

  initial begin
    vecs[0]  = '{2'd0, 24'hFF0000, 8'h7F};
    vecs[1]  = '{2'd1, 24'h0A1420, 8'h14};
    vecs[2]  = '{2'd2, 24'hFFFFFF, 8'hFF};
    vecs[3]  = '{2'd3, 24'h123456, 8'h00};
    vecs[4]  = '{2'd0, 24'h102030, 8'h20};
    vecs[5]  = '{2'd1, 24'hFFFFFF, 8'hFF};
    vecs[6]  = '{2'd2, 24'hFF0000, 8'h4C};
    vecs[7]  = '{2'd2, 24'h00FF00, 8'h95};
    vecs[8]  = '{2'd2, 24'h0000FF, 8'h1C};
    vecs[9]  = '{2'd1, 24'h050000, 8'h01};
    vecs[10] = '{2'd0, 24'h0102FF, 8'h80};
    vecs[11] = '{2'd0, 24'h000000, 8'h00};
    vecs[12] = '{2'd2, 24'h804020, 8'h4F};
    vecs[13] = '{2'd3, 24'hABCDEF, 8'h00};

    rst       = 1'b1;
    mode      = 2'd0;
    in_valid  = 1'b0;
    in_pix    = 24'd0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_pix", {8'd0, out_pix}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Single pixel latency: accepted at edge 1, visible after edge 2
    @(posedge clk); #1;
    in_valid = 1'b1; mode = 2'd0; in_pix = 24'hFF0000; cur_exp = pack(2'd0, 8'h7F, 24'hFF0000);
    @(negedge clk);
    check("lat_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_cycle1_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("lat_cycle2_valid", {31'd0, out_valid}, 32'd1);
    check("lat_cycle2_pix", {8'd0, out_pix}, {8'd0, pack(2'd0, 8'h7F, 24'hFF0000)});
    @(negedge clk);
    check("lat_px_count", {16'd0, px_count}, 32'd1);
    check("lat_hold_pix", {8'd0, out_pix}, {8'd0, pack(2'd0, 8'h7F, 24'hFF0000)});

    // Table: streamed back to back, compared by the scoreboard
    for (int i = 0; i < 14; i++) send(vecs[i].m, vecs[i].pix, pack(vecs[i].m, vecs[i].g, vecs[i].pix));
    idle();
    drain();

    // Four back-to-back pixels with alternating modes, outputs on consecutive cycles
    xfer_cyc.delete();
    send(2'd0, 24'hFF0000, pack(2'd0, 8'h7F, 24'hFF0000));
    send(2'd1, 24'h0A1420, pack(2'd1, 8'h14, 24'h0A1420));
    send(2'd2, 24'hFFFFFF, pack(2'd2, 8'hFF, 24'hFFFFFF));
    send(2'd3, 24'h123456, 24'h123456);
    idle();
    drain();
    check("b2b_count", xfer_cyc.size(), 32'd4);
    if (xfer_cyc.size() == 4) begin
      for (int i = 1; i < 4; i++) check("b2b_consecutive", xfer_cyc[i] - xfer_cyc[0], i);
    end

    // Stall: out_ready low for 6 cycles while input is offered
    @(posedge clk); #1;
    out_ready = 1'b0;
    acc = 0; have_hold = 0; stab_bad = 0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(vecs[i + 4].m, vecs[i + 4].pix, pack(vecs[i + 4].m, vecs[i + 4].g, vecs[i + 4].pix));
      end
      begin
        @(posedge clk); #1;
        repeat (6) begin
          @(negedge clk);
          if (in_valid && in_ready) acc++;
          if (out_valid) begin
            if (!have_hold) begin
              hold_pix  = out_pix;
              have_hold = 1;
            end else if (out_pix !== hold_pix) begin
              stab_bad++;
            end
          end
        end
        check("stall_accepted", acc, 32'd2);
        check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        check("stall_out_valid", {31'd0, out_valid}, 32'd1);
        check("stall_pix_stable", stab_bad, 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    idle();
    drain();

    // Random out_ready pattern over the whole table; scoreboard checks order and count
    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 14; i++) send(vecs[i].m, vecs[i].pix, pack(vecs[i].m, vecs[i].g, vecs[i].pix));
        idle();
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    // Reset with two pixels in flight
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(2'd0, 24'h102030, pack(2'd0, 8'h20, 24'h102030));
    send(2'd2, 24'h804020, pack(2'd2, 8'h4F, 24'h804020));
    idle();
    @(negedge clk);
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    do_reset();
    @(negedge clk);
    check("post_rst_valid", {31'd0, out_valid}, 32'd0);
    check("post_rst_count", {16'd0, px_count}, 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_no_stale", {31'd0, out_valid}, 32'd0);
    check("post_rst_count2", {16'd0, px_count}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
